// File: rtl/vproc_bus_arbiter.sv
// vproc_bus_arbiter
// Round-robin arbiter that lets several VProc bus masters share one
// downstream slave. It runs one transfer at a time, routes acks and read
// data back to the granted master, and uses a watchdog to finish
// transfers that a hung slave never acknowledges.
// Optional burst locking is compiled in with `define VPROC_ARB_BURST_LOCK_EN.

module vproc_bus_arbiter #(
  parameter int          NUM_MASTERS = 2,
  parameter int          TIMEOUT     = 256,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [32*NUM_MASTERS-1:0] MAddr,
  input  logic [NUM_MASTERS-1:0]    MWE,
  input  logic [NUM_MASTERS-1:0]    MRD,
  input  logic [32*NUM_MASTERS-1:0] MDataOut,
  input  logic [NUM_MASTERS-1:0]    MBurstFirst,
  input  logic [NUM_MASTERS-1:0]    MBurstLast,
  output logic [31:0]               MDataIn,
  output logic [NUM_MASTERS-1:0]    MWRAck,
  output logic [NUM_MASTERS-1:0]    MRDAck,
  output logic [31:0]               SAddr,
  output logic [31:0]               SDataOut,
  output logic                      SWE,
  output logic                      SRD,
  output logic                      SBurstFirst,
  output logic                      SBurstLast,
  input  logic [31:0]               SDataIn,
  input  logic                      SWRAck,
  input  logic                      SRDAck,
  output logic [NUM_MASTERS-1:0]    Grant,
  output logic                      Timeout
);

  localparam int               IDX_W     = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_MASTERS - 1);

`ifdef VPROC_ARB_BURST_LOCK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCK   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [15:0]            wdog_q, wdog_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   rd_q, rd_d;
  logic                   bf_q, bf_d;
  logic                   bl_q, bl_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
`ifdef VPROC_ARB_BURST_LOCK_EN
  logic                   lock_q, lock_d;
`endif

  logic [NUM_MASTERS-1:0] req;
  logic                   anyReq;
  logic [IDX_W-1:0]       winIdx;
  logic [IDX_W-1:0]       selIdx;
  logic [31:0]            selAddr;
  logic [31:0]            selData;
  logic                   selWe;
  logic                   selRd;
  logic                   selBf;
  logic                   selBl;
  logic                   selReq;
  logic [NUM_MASTERS-1:0] selOneHot;
  logic                   slvAck;
  logic                   expire;
  logic                   done;
  logic                   load;

  // A master is requesting whenever either of its strobes is high.
  assign req = MWE | MRD;

  // Round-robin pick: lowest requester above the last winner, otherwise wrap to the lowest requester overall.
  always_comb begin
    anyReq = 1'b0;
    winIdx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        anyReq = 1'b1;
        winIdx = IDX_W'(i);
      end
    end
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > last_q)) begin
        winIdx = IDX_W'(i);
      end
    end
  end

  // While a burst lock is pending the owner is re-granted; otherwise the round-robin winner is loaded.
`ifdef VPROC_ARB_BURST_LOCK_EN
  assign selIdx = (state_q == ST_LOCK) ? last_q : winIdx;
`else
  assign selIdx = winIdx;
`endif

  // Mux the selected master's request fields; a write wins when both strobes are set.
  always_comb begin
    selAddr   = '0;
    selData   = '0;
    selWe     = 1'b0;
    selRd     = 1'b0;
    selBf     = 1'b0;
    selBl     = 1'b0;
    selReq    = 1'b0;
    selOneHot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (selIdx == IDX_W'(i)) begin
        selAddr      = MAddr[32*i +: 32];
        selData      = MDataOut[32*i +: 32];
        selWe        = MWE[i];
        selRd        = MRD[i] & ~MWE[i];
        selBf        = MBurstFirst[i];
        selBl        = MBurstLast[i];
        selReq       = req[i];
        selOneHot[i] = 1'b1;
      end
    end
  end

  // Completion detection: a matching slave ack wins over the watchdog, which only fires on a silent slave.
  always_comb begin
    slvAck = (SWRAck & we_q) | (SRDAck & rd_q);
    expire = (state_q == ST_ACTIVE) & ~slvAck & (wdog_q == WDOG_LAST);
    done   = (state_q == ST_ACTIVE) & (slvAck | expire);
  end

  // Ack routing back to the granted master, with error data substituted on a timed-out read.
  always_comb begin
    MWRAck  = grant_q & {NUM_MASTERS{we_q & (SWRAck | expire)}};
    MRDAck  = grant_q & {NUM_MASTERS{rd_q & (SRDAck | expire)}};
    MDataIn = (expire & rd_q) ? ERR_DATA : SDataIn;
    Timeout = expire;
  end

  assign SAddr       = addr_q;
  assign SDataOut    = wdata_q;
  assign SWE         = we_q;
  assign SRD         = rd_q;
  assign SBurstFirst = bf_q;
  assign SBurstLast  = bl_q;
  assign Grant       = grant_q;

  // Next-state logic: sequence IDLE -> ACTIVE -> IDLE (or LOCK) and load the slave-side registers.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd_d    = rd_q;
    bf_d    = bf_q;
    bl_d    = bl_q;
    grant_d = grant_q;
    load    = 1'b0;
`ifdef VPROC_ARB_BURST_LOCK_EN
    lock_d  = lock_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          load    = 1'b1;
          last_d  = winIdx;
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        wdog_d = wdog_q + 16'd1;
        if (done) begin
          we_d    = 1'b0;
          rd_d    = 1'b0;
          bf_d    = 1'b0;
          bl_d    = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
`ifdef VPROC_ARB_BURST_LOCK_EN
          if (!expire && (bf_q || lock_q) && !bl_q) begin
            lock_d  = 1'b1;
            state_d = ST_LOCK;
          end else begin
            lock_d  = 1'b0;
          end
`endif
        end
      end

`ifdef VPROC_ARB_BURST_LOCK_EN
      ST_LOCK: begin
        if (selReq) begin
          load    = 1'b1;
          state_d = ST_ACTIVE;
        end else begin
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      addr_d  = selAddr;
      wdata_d = selData;
      we_d    = selWe;
      rd_d    = selRd;
      bf_d    = selBf;
      bl_d    = selBl;
      grant_d = selOneHot;
      wdog_d  = '0;
    end
  end

  // State register; reset parks the pointer on the top master so master 0 wins first.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      wdog_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      bf_q    <= 1'b0;
      bl_q    <= 1'b0;
      grant_q <= '0;
`ifdef VPROC_ARB_BURST_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      bf_q    <= bf_d;
      bl_q    <= bl_d;
      grant_q <= grant_d;
`ifdef VPROC_ARB_BURST_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// tb_vproc_bus_arbiter
// Drives three masters and a behavioural slave into vproc_bus_arbiter and
// compares every output, every cycle, against a transaction-level model of
// the arbitration rules. Honours VPROC_ARB_BURST_LOCK_EN like the design.

module tb_vproc_bus_arbiter;

  localparam int          NM  = 3;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic              Clk;
  logic              nReset;
  logic [32*NM-1:0]  MAddr;
  logic [NM-1:0]     MWE;
  logic [NM-1:0]     MRD;
  logic [32*NM-1:0]  MDataOut;
  logic [NM-1:0]     MBurstFirst;
  logic [NM-1:0]     MBurstLast;
  logic [31:0]       MDataIn;
  logic [NM-1:0]     MWRAck;
  logic [NM-1:0]     MRDAck;
  logic [31:0]       SAddr;
  logic [31:0]       SDataOut;
  logic              SWE;
  logic              SRD;
  logic              SBurstFirst;
  logic              SBurstLast;
  logic [31:0]       SDataIn;
  logic              SWRAck;
  logic              SRDAck;
  logic [NM-1:0]     Grant;
  logic              Timeout;

  vproc_bus_arbiter #(
    .NUM_MASTERS (NM),
    .TIMEOUT     (TO),
    .ERR_DATA    (ERR)
  ) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .MAddr       (MAddr),
    .MWE         (MWE),
    .MRD         (MRD),
    .MDataOut    (MDataOut),
    .MBurstFirst (MBurstFirst),
    .MBurstLast  (MBurstLast),
    .MDataIn     (MDataIn),
    .MWRAck      (MWRAck),
    .MRDAck      (MRDAck),
    .SAddr       (SAddr),
    .SDataOut    (SDataOut),
    .SWE         (SWE),
    .SRD         (SRD),
    .SBurstFirst (SBurstFirst),
    .SBurstLast  (SBurstLast),
    .SDataIn     (SDataIn),
    .SWRAck      (SWRAck),
    .SRDAck      (SRDAck),
    .Grant       (Grant),
    .Timeout     (Timeout)
  );

  // Free-running 10-unit clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Pending request of each master, held until that master is acked
  bit          pReq[NM];
  bit          pWe[NM];
  bit          pRd[NM];
  logic [31:0] pAddr[NM];
  logic [31:0] pData[NM];
  bit          pBf[NM];
  bit          pBl[NM];
  int          pBurstLeft[NM];

  // Reference model: the transfer currently on the slave bus, if any
  bit          mBusy;
  int          mOwner;
  int          mAge;
  int          mLast;
  bit          mIsWrite;
  bit          mBf;
  bit          mBl;
  logic [31:0] mAddr;
  logic [31:0] mData;
  bit          mLockHeld;
  bit          mLockWait;

  bit          eDone;
  bit          eExpire;
  int          eAckOwner = -1;

  int          slaveMode;
  int          reqPct;
  int          forceDir;
  bit [NM-1:0] allowMask;

  int          sweCount;
  int          ack0Count;
  int          toCount;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy     = 1'b0;
    mOwner    = 0;
    mAge      = 0;
    mLast     = NM - 1;
    mIsWrite  = 1'b0;
    mBf       = 1'b0;
    mBl       = 1'b0;
    mAddr     = '0;
    mData     = '0;
    mLockHeld = 1'b0;
    mLockWait = 1'b0;
  endtask

  task automatic startXfer(input int w);
    mBusy    = 1'b1;
    mAge     = 0;
    mOwner   = w;
    mIsWrite = pWe[w];
    mAddr    = pAddr[w];
    mData    = pData[w];
    mBf      = pBf[w];
    mBl      = pBl[w];
  endtask

  // Advance the model by one clock edge using the inputs of the cycle just ended
  task automatic modelStep();
    bit found;
    if (!nReset) return;
    if (mBusy) begin
      mAge++;
      if (eDone) begin
        mBusy = 1'b0;
`ifdef VPROC_ARB_BURST_LOCK_EN
        if (!eExpire && (mBf || mLockHeld) && !mBl) begin
          mLockHeld = 1'b1;
          mLockWait = 1'b1;
        end else begin
          mLockHeld = 1'b0;
        end
`endif
      end
    end else if (mLockWait) begin
      mLockWait = 1'b0;
      if (pReq[mLast]) startXfer(mLast);
      else mLockHeld = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NM; k++) begin
        int idx;
        idx = (mLast + k) % NM;
        if (!found && pReq[idx]) begin
          found = 1'b1;
          mLast = idx;
          startXfer(idx);
        end
      end
    end
  endtask

  // Compare every DUT output with what the model predicts for this cycle
  task automatic checkCycle();
    bit          slaveAck;
    logic [NM-1:0] eGrant;
    logic [NM-1:0] eOwnerHot;
    slaveAck  = mBusy && (mIsWrite ? SWRAck : SRDAck);
    eExpire   = mBusy && !slaveAck && (mAge == TO - 1);
    eDone     = slaveAck || eExpire;
    eOwnerHot = NM'(1) << mOwner;
    eGrant    = mBusy ? eOwnerHot : '0;
    eAckOwner = eDone ? mOwner : -1;

    checkOutput("Grant",       64'(Grant),       64'(eGrant));
    checkOutput("SWE",         64'(SWE),         64'(mBusy && mIsWrite));
    checkOutput("SRD",         64'(SRD),         64'(mBusy && !mIsWrite));
    checkOutput("SBurstFirst", 64'(SBurstFirst), 64'(mBusy && mBf));
    checkOutput("SBurstLast",  64'(SBurstLast),  64'(mBusy && mBl));
    checkOutput("SAddr",       64'(SAddr),       64'(mAddr));
    checkOutput("SDataOut",    64'(SDataOut),    64'(mData));
    checkOutput("MWRAck",      64'(MWRAck),      64'((eDone && mIsWrite) ? eOwnerHot : '0));
    checkOutput("MRDAck",      64'(MRDAck),      64'((eDone && !mIsWrite) ? eOwnerHot : '0));
    checkOutput("MDataIn",     64'(MDataIn),     64'((eExpire && !mIsWrite) ? ERR : SDataIn));
    checkOutput("Timeout",     64'(Timeout),     64'(eExpire));

    if (SWE) sweCount++;
    if (MWRAck[0]) ack0Count++;
    if (Timeout) toCount++;
  endtask

  task automatic issueReq(input int i, input bit we, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit bf, input bit bl, input int left);
    pReq[i]       = 1'b1;
    pWe[i]        = we;
    pRd[i]        = rd;
    pAddr[i]      = a;
    pData[i]      = d;
    pBf[i]        = bf;
    pBl[i]        = bl;
    pBurstLeft[i] = left;
  endtask

  task automatic newRequest(input int i);
    int dir;
    int len;
    bit we;
    bit rd;
    dir = (forceDir != 0) ? forceDir : int'($urandom_range(1, 10));
    if (dir == 1 || (dir > 2 && dir <= 6)) begin
      we = 1'b0; rd = 1'b1;
    end else if (dir == 10) begin
      we = 1'b1; rd = 1'b1;
    end else begin
      we = 1'b1; rd = 1'b0;
    end
    len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
    issueReq(i, we, rd, $urandom, $urandom, len > 1, 1'b0, len - 1);
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NM; i++) begin
      MWE[i]             = pReq[i] & pWe[i];
      MRD[i]             = pReq[i] & pRd[i];
      MAddr[32*i +: 32]    = pAddr[i];
      MDataOut[32*i +: 32] = pData[i];
      MBurstFirst[i]     = pReq[i] & pBf[i];
      MBurstLast[i]      = pReq[i] & pBl[i];
    end
  endtask

  // Masters react to their acks, new requests appear, and the slave answers
  task automatic applyStimulus();
    for (int i = 0; i < NM; i++) begin
      if (eAckOwner == i) begin
        pReq[i] = 1'b0;
        if (pBurstLeft[i] > 0) begin
          issueReq(i, pWe[i], pRd[i], pAddr[i] + 32'd4, $urandom, 1'b0,
                   pBurstLeft[i] == 1, pBurstLeft[i] - 1);
        end
      end
    end
    eAckOwner = -1;
    for (int i = 0; i < NM; i++) begin
      if (!pReq[i] && allowMask[i] && (int'($urandom_range(0, 99)) < reqPct)) newRequest(i);
    end
    driveInputs();
    case (slaveMode)
      0: begin
        SWRAck = ($urandom_range(0, 99) < 40);
        SRDAck = ($urandom_range(0, 99) < 40);
      end
      1: begin
        SWRAck = 1'b1;
        SRDAck = 1'b1;
      end
      3: begin
        SWRAck = mBusy && (mAge == TO - 1);
        SRDAck = mBusy && (mAge == TO - 1);
      end
      default: begin
        SWRAck = 1'b0;
        SRDAck = 1'b0;
      end
    endcase
    SDataIn = $urandom;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge Clk);
      checkCycle();
      @(posedge Clk);
      modelStep();
      #1;
      applyStimulus();
    end
  endtask

  // Directed scenarios followed by a long randomized run
  initial begin
    nReset    = 1'b0;
    SDataIn   = 32'h0;
    SWRAck    = 1'b0;
    SRDAck    = 1'b0;
    slaveMode = 2;
    reqPct    = 0;
    forceDir  = 0;
    allowMask = '0;
    for (int i = 0; i < NM; i++) begin
      pReq[i] = 1'b0; pWe[i] = 1'b0; pRd[i] = 1'b0; pAddr[i] = '0; pData[i] = '0;
      pBf[i] = 1'b0; pBl[i] = 1'b0; pBurstLeft[i] = 0;
    end
    driveInputs();
    modelReset();

    runCycles(3);
    nReset = 1'b1;
    runCycles(2);

    $display("[TB] single write from master 0");
    slaveMode = 1;
    sweCount  = 0;
    ack0Count = 0;
    issueReq(0, 1'b1, 1'b0, 32'h100, 32'h12345678, 1'b0, 1'b0, 0);
    driveInputs();
    runCycles(5);
    checkOutput("singleSweCycles", 64'(sweCount), 64'd1);
    checkOutput("singleAckPulses", 64'(ack0Count), 64'd1);

    $display("[TB] masters 0 and 1 reading continuously");
    allowMask = 3'b011;
    reqPct    = 100;
    forceDir  = 1;
    runCycles(14);
    allowMask = '0;
    runCycles(6);

    $display("[TB] slave never acks a read");
    slaveMode = 2;
    forceDir  = 0;
    toCount   = 0;
    issueReq(2, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0, 1'b0, 0);
    driveInputs();
    runCycles(8);
    checkOutput("watchdogPulses", 64'(toCount), 64'd1);
    slaveMode = 1;
    issueReq(1, 1'b0, 1'b1, 32'h304, 32'h0, 1'b0, 1'b0, 0);
    driveInputs();
    runCycles(4);

    $display("[TB] slave ack coincides with watchdog expiry");
    slaveMode = 3;
    toCount   = 0;
    issueReq(0, 1'b0, 1'b1, 32'h400, 32'h0, 1'b0, 1'b0, 0);
    issueReq(1, 1'b1, 1'b0, 32'h404, 32'h55AA55AA, 1'b0, 1'b0, 0);
    driveInputs();
    runCycles(14);
    checkOutput("coincidentTimeouts", 64'(toCount), 64'd0);

    $display("[TB] master 0 burst against master 1");
    slaveMode = 1;
    issueReq(0, 1'b1, 1'b0, 32'h200, $urandom, 1'b1, 1'b0, 3);
    allowMask = 3'b010;
    reqPct    = 100;
    forceDir  = 2;
    issueReq(1, 1'b1, 1'b0, 32'h800, $urandom, 1'b0, 1'b0, 0);
    driveInputs();
    runCycles(24);
    allowMask = '0;
    runCycles(10);

    $display("[TB] reset in the middle of a transfer");
    slaveMode = 2;
    forceDir  = 0;
    issueReq(1, 1'b0, 1'b1, 32'h500, 32'h0, 1'b0, 1'b0, 0);
    driveInputs();
    runCycles(2);
    nReset = 1'b0;
    modelReset();
    #1;
    checkOutput("rstGrant", 64'(Grant), 64'd0);
    checkOutput("rstSWE",   64'(SWE),   64'd0);
    checkOutput("rstSRD",   64'(SRD),   64'd0);
    checkOutput("rstSAddr", 64'(SAddr), 64'd0);
    issueReq(0, 1'b1, 1'b0, 32'h600, 32'hCAFEF00D, 1'b0, 1'b0, 0);
    driveInputs();
    slaveMode = 1;
    runCycles(2);
    nReset = 1'b1;
    runCycles(8);

    $display("[TB] randomized traffic");
    allowMask = '1;
    forceDir  = 0;
    for (int blk = 0; blk < 24; blk++) begin
      reqPct = int'($urandom_range(20, 90));
      case ($urandom_range(0, 4))
        0, 1:    slaveMode = 0;
        2:       slaveMode = 1;
        3:       slaveMode = 3;
        default: slaveMode = 2;
      endcase
      runCycles(40);
    end
    allowMask = '0;
    slaveMode = 1;
    runCycles(20);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vproc_bus_arbiter.md
# vproc_bus_arbiter

Round-robin arbiter that shares one downstream memory-mapped slave between up to `NUM_MASTERS` VProc bus masters. It sits between the VProc bus ports (Addr/WE/RD/DataOut/DataIn/WRAck/RDAck/BurstFirst/BurstLast) and a single slave such as a test memory or register block. It sequences one transfer at a time, routes acknowledges and read data back to the granted master, and protects the bus against a hung slave with a watchdog.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters, 2..8.
- `TIMEOUT`, 256: cycles to wait for a slave ack before error completion, 2..65535.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on a timed-out read.
- Clk  in  1  system clock; all state on posedge.
- nReset  in  1  asynchronous, active-low reset.
- MAddr  in  32*NUM_MASTERS  master addresses; master i occupies bits [32i+31:32i].
- MWE  in  NUM_MASTERS  master write request.
- MRD  in  NUM_MASTERS  master read request.
- MDataOut  in  32*NUM_MASTERS  master write data.
- MBurstFirst  in  NUM_MASTERS  master first-in-burst flag.
- MBurstLast  in  NUM_MASTERS  master last-in-burst flag.
- MDataIn  out  32  read data, common to all masters.
- MWRAck  out  NUM_MASTERS  per-master write ack.
- MRDAck  out  NUM_MASTERS  per-master read ack.
- SAddr, SDataOut  out  32  registered slave address / write data.
- SWE, SRD  out  1  registered slave strobes.
- SBurstFirst, SBurstLast  out  1  registered burst flags, forwarded from the granted master.
- SDataIn  in  32  slave read data.
- SWRAck, SRDAck  in  1  slave acks.
- Grant  out  NUM_MASTERS  one-hot current grant, all zero when idle.
- Timeout  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Request: master i requests when `MWE[i]|MRD[i]`. If both strobes are high, the transfer is treated as a write.
- States:
  - IDLE: with any request, select a winner, load the slave outputs from that master, set Grant, clear the watchdog, and go to ACTIVE. With no request, stay in IDLE.
  - ACTIVE: hold the slave outputs stable. On `SWRAck` (while SWE) or `SRDAck` (while SRD), drop SWE/SRD/burst flags and Grant, and go to IDLE (or LOCK; see Configuration).
  - LOCK: exists only when burst locking is compiled in (see Configuration).
- Round-robin: a `last` pointer records the most recent winner. The search starts at `last+1` modulo NUM_MASTERS, and the lowest index after `last` wins. `last` updates only when a grant is issued.
- Ack routing (combinational): `MWRAck = Grant & {NUM_MASTERS{SWRAck & SWE}}`; `MRDAck` is formed the same way from SRDAck/SRD. `MDataIn = SDataIn`. Acks from the slave while IDLE are ignored.
- Watchdog: a 16-bit counter increments each ACTIVE cycle. When it reaches TIMEOUT-1 with no ack:
  - pulse Timeout;
  - assert the granted master's ack for that one cycle, with `MDataIn = ERR_DATA` on reads;
  - complete the transfer as if acked.
  A slave ack in the same cycle takes precedence, and no Timeout pulse is generated.
- Reset (async, any state): state goes to IDLE; `last = NUM_MASTERS-1`, so master 0 wins first.

## Timing
- Reset values: SAddr=0, SDataOut=0, SWE=0, SRD=0, SBurstFirst=0, SBurstLast=0, Grant=0, Timeout=0. MWRAck, MRDAck and MDataIn follow their combinational terms, so they are 0 and SDataIn respectively.
- Request seen at edge N: slave strobes and Grant are high after edge N.
- Zero-wait slave (ack combinational on strobe): the ack is sampled at edge N+1, and the strobe is low after N+1. Peak throughput is one transfer per 2 cycles.
- The master's new request, which it updates on its ack edge, is arbitrated no earlier than the edge after it becomes visible.
- The slave outputs never change while in ACTIVE.

## Configuration
- `VPROC_ARB_BURST_LOCK_EN` defined:
  - An ack on a transfer with SBurstFirst=1 or a lock already held, and with SBurstLast=0, goes to LOCK instead of IDLE.
  - In LOCK, if the same master is requesting, re-grant it immediately to ACTIVE, ignoring the other masters. If it is not requesting, go to IDLE.
  - The lock clears on an ack with SBurstLast=1, on a timeout, or on reset.
- Undefined: no LOCK state. Every completed transfer returns to IDLE and re-arbitrates, so bursts from different masters may interleave.

## Test plan
- Single master 0 write, Addr=0x100, data 0x12345678, zero-wait slave -> SWE high for exactly 1 cycle with SAddr=0x100 and SDataOut=0x12345678; MWRAck[0] pulses once; Grant returns to 0.
- Masters 0 and 1 both reading continuously -> grants alternate 0,1,0,1. Each MRDAck goes only to the granted master, and MDataIn equals SDataIn.
- Slave never acks a read, TIMEOUT=4 -> Timeout and MRDAck pulse together 4 cycles after the grant, with MDataIn=0xDEADBEEF; the next request is then served normally.
- With the lock enabled: master 0 does a 4-word burst while master 1 requests throughout -> all 4 master-0 transfers complete before Grant[1]. Without the lock, the grants interleave.
- Assert nReset low mid-ACTIVE -> all registered outputs are 0 immediately. After release, master 0 wins the first tie.
- Slave ack and the watchdog expiry in the same cycle -> normal ack with slave data; no Timeout pulse.
